// File: rtl/ula_sched.sv
// ula_sched: two-requester round-robin front end for a single-cycle ULA.
// One operation is in flight at a time; operands are registered on accept,
// the ULA result is captured one cycle later and held until the consumer
// takes it.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | accepting; arbiter may grant one requester
// ST_EXEC    | ULA evaluating the latched operands
// ST_RESP    | result held on rsp_*, waiting for rsp_ready
module ula_sched (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_select,
  input  logic [31:0] req0_data1,
  input  logic [31:0] req0_data2,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_select,
  input  logic [31:0] req1_data1,
  input  logic [31:0] req1_data2,

  output logic [3:0]  select_ula,
  output logic [31:0] data1_in,
  output logic [31:0] data2_in,
  input  logic [31:0] data_out,
  input  logic        zero,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_zero
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [3:0]  op_sel_q, op_sel_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic        op_id_q, op_id_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_zero_q, rsp_zero_d;

  logic        grant0, grant1;
  logic        accept;
  logic        grant_id;

  // Round-robin arbitration: a lone requester wins; under contention the
  // requester that did not win last time wins. Readies are masked by rst_n
  // so they read 0 for the whole reset window, even with valids asserted.
  always_comb begin
    grant0     = req0_valid && (!req1_valid || last_grant_q);
    grant1     = req1_valid && (!req0_valid || !last_grant_q);
    req0_ready = rst_n && (state_q == ST_IDLE) && grant0;
    req1_ready = rst_n && (state_q == ST_IDLE) && grant1;
    accept     = req0_ready || req1_ready;
    grant_id   = req1_ready;
  end

  // Next-state and register-update logic for the three-state sequencer.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_sel_d     = op_sel_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_id_d      = op_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_zero_d   = rsp_zero_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_sel_d     = grant_id ? req1_select : req0_select;
          op_a_d       = grant_id ? req1_data1  : req0_data1;
          op_b_d       = grant_id ? req1_data2  : req0_data2;
          op_id_d      = grant_id;
          last_grant_d = grant_id;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_data_d = data_out;
        rsp_zero_d = zero;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      op_sel_q     <= 4'd0;
      op_a_q       <= 32'd0;
      op_b_q       <= 32'd0;
      op_id_q      <= 1'b0;
      rsp_data_q   <= 32'd0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_sel_q     <= op_sel_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_id_q      <= op_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  // ULA operands come only from registers, never from the request ports.
  assign select_ula = op_sel_q;
  assign data1_in   = op_a_q;
  assign data2_in   = op_b_q;

  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_id     = op_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_zero   = rsp_zero_q;

endmodule

// File: doc/ula_sched.md
ULA_SCHED -- requirements
Module: ula_sched

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-002 The block SHALL have these requester-0 ports: req0_valid input 1, operation request; req0_ready output 1, request accepted this cycle; req0_select input 4, ULA op code; req0_data1 input 32, operand 1; req0_data2 input 32, operand 2.
REQ-003 The block SHALL have requester-1 ports req1_valid, req1_ready, req1_select, req1_data1 and req1_data2, with the same directions, widths and meanings as requester 0.
REQ-004 The block SHALL have these ULA-side ports: select_ula output 4; data1_in output 32; data2_in output 32; data_out input 32, ULA result; zero input 1, ULA zero flag.
REQ-005 The block SHALL have these response ports: rsp_valid output 1, result available; rsp_ready input 1, consumer accepts; rsp_id output 1, requester that issued the op; rsp_data output 32, latched result; rsp_zero output 1, latched zero flag.

Function
REQ-006 The FSM SHALL have exactly three states with the following meaning: IDLE, accepting; EXEC, ULA evaluating latched operands; RESP, result held.
REQ-007 In IDLE, the arbiter SHALL grant requester k when only reqk_valid=1 is asserted.
REQ-008 In IDLE, when both req0_valid and req1_valid are 1, the arbiter SHALL grant the requester not equal to last_grant (round-robin).
REQ-009 reqk_ready SHALL equal (state==IDLE && grant==k), combinationally; at most one ready SHALL be 1 in any cycle.
REQ-010 An accept (valid&&ready) SHALL latch select, data1, data2 and the requester id into operation registers, set last_grant=k, and move IDLE->EXEC.
REQ-011 select_ula, data1_in and data2_in SHALL be driven directly from the operation registers in all states, with no combinational path from the req* inputs.
REQ-012 In EXEC, on the next clock edge, data_out SHALL be latched into rsp_data and zero into rsp_zero, and the FSM SHALL move EXEC->RESP.
REQ-013 rsp_valid SHALL be 1 iff state==RESP; rsp_data, rsp_zero and rsp_id SHALL be stable while rsp_valid=1.
REQ-014 In RESP with rsp_ready=1, the FSM SHALL move RESP->IDLE; with rsp_ready=0, it SHALL stay in RESP indefinitely.
REQ-015 No request SHALL be accepted in EXEC or RESP; the minimum accept-to-accept spacing SHALL be 3 cycles, and the accept-to-rsp_valid latency SHALL be 2 cycles.
REQ-016 Requesters SHALL hold valid and payload stable until ready; the block SHALL sample the payload only on the accept cycle.
REQ-017 Op codes outside 1..10 SHALL be forwarded unchanged and complete normally, returning the ULA default result (rsp_data=0, rsp_zero=1).
REQ-018 A requester that deasserts valid before being granted SHALL lose nothing; no request SHALL be queued internally.
REQ-019 A requester kept continuously valid SHALL be granted within 2 accepts when contending.

Reset
REQ-020 While rst_n=0, the block SHALL immediately force state=IDLE, last_grant=1, operation registers=0 (select_ula=0, data1_in=0, data2_in=0), rsp_valid=0, rsp_id=0, rsp_data=0, rsp_zero=0, req0_ready=0 and req1_ready=0.
REQ-021 A reset asserted in EXEC or RESP SHALL discard the in-flight operation without producing any response.
REQ-022 On the first IDLE cycle after reset release, if both requesters are valid, requester 0 SHALL be granted.

Verification
REQ-023 The bench SHALL cover a single op: req0 ADD(1), 5 and 7, rsp_ready=1 -> req0_ready=1 at cycle 0, rsp_valid=1 at cycle 2 with rsp_data=12, rsp_zero=0, rsp_id=0, IDLE at cycle 3.
REQ-024 The bench SHALL cover contention: both valid continuously, req0 SUB(2) 9,9 and req1 SLTU(5) 1,2 -> accepts alternate 0,1,0,1; the req0 results are 0 with rsp_zero=1; the req1 results are 1.
REQ-025 The bench SHALL cover backpressure: rsp_ready=0 for 10 cycles after an XOR(8) of 0xF0F0F0F0 and 0x0F0F0F0F -> rsp_valid stays 1 with rsp_data=0xFFFFFFFF unchanged, both readies stay 0; then rsp_ready=1 -> IDLE next cycle.
REQ-026 The bench SHALL cover signed shift: req1 SRA(7), 0x80000000 and 4 -> rsp_data=0xF8000000, rsp_id=1.
REQ-027 The bench SHALL cover an invalid op code: req0 select=0xF with 3 and 4 -> rsp_data=0, rsp_zero=1, normal 2-cycle latency.
REQ-028 The bench SHALL cover reset mid-operation: rst_n pulsed low during EXEC -> rsp_valid never asserts for that op, all outputs are 0 asynchronously, and after release with both requesters valid, req0 is granted first.
